// File: rtl/seq_step_ctrl.sv
// Run controller for the 9-bit step sequencer: start/stop, pause, single-step,
// programmable last step and loop count, with adv/wrap/done strobes.
module seq_step_ctrl #(
    parameter int STATE_W  = 9,
    parameter int LOOP_W   = 8,
    parameter int DEF_LAST = 259
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               step,
    input  logic [STATE_W-1:0] last_step,
    input  logic [LOOP_W-1:0]  loop_count,
    output logic [STATE_W-1:0] state,
    output logic               busy,
    output logic               adv,
    output logic               wrap,
    output logic               done,
    output logic [1:0]         ctrl_dbg
);

    // Handshake: none; start/step are single-cycle pulses sampled on the rising
    // edge, stop/pause are levels. Priority on every edge: stop > start > pause > step.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } ctrl_t;

    ctrl_t              ctrl_q, ctrl_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic [STATE_W-1:0] last_q, last_d;
    logic [LOOP_W-1:0]  loops_q, loops_d;
    logic               inf_q, inf_d;
    logic               adv_q, adv_d;
    logic               wrap_q, wrap_d;
    logic               done_q, done_d;
    logic               do_adv;

    always_comb begin
        ctrl_d  = ctrl_q;
        state_d = state_q;
        last_d  = last_q;
        loops_d = loops_q;
        inf_d   = inf_q;
        adv_d   = 1'b0;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        do_adv  = 1'b0;

        if (stop) begin
            ctrl_d  = S_IDLE;
            state_d = '0;
        end else if (start && (ctrl_q == S_IDLE || ctrl_q == S_DONE)) begin
            last_d  = last_step;
            loops_d = loop_count;
            inf_d   = (loop_count == '0);
            state_d = '0;
            ctrl_d  = pause ? S_HOLD : S_RUN;
        end else begin
            case (ctrl_q)
                S_RUN: begin
                    if (pause) ctrl_d = S_HOLD;
                    else       do_adv = 1'b1;
                end
                S_HOLD: begin
                    if (!pause)    ctrl_d = S_RUN;
                    else if (step) do_adv = 1'b1;
                end
                S_DONE:  ctrl_d = S_IDLE;
                default: ctrl_d = S_IDLE;
            endcase
        end

        // Wrap is decided by compare so the counter can never run past last_q.
        if (do_adv) begin
            adv_d = 1'b1;
            if (state_q < last_q) begin
                state_d = state_q + 1'b1;
            end else begin
                state_d = '0;
                wrap_d  = 1'b1;
                if (!inf_q && loops_q == LOOP_W'(1)) begin
                    ctrl_d  = S_DONE;
                    done_d  = 1'b1;
                    loops_d = '0;
                end else if (!inf_q) begin
                    loops_d = loops_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= S_IDLE;
            state_q <= '0;
            last_q  <= '0;
            loops_q <= '0;
            inf_q   <= 1'b0;
            adv_q   <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            state_q <= state_d;
            last_q  <= last_d;
            loops_q <= loops_d;
            inf_q   <= inf_d;
            adv_q   <= adv_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign state    = state_q;
    assign busy     = (ctrl_q == S_RUN) || (ctrl_q == S_HOLD);
    assign adv      = adv_q;
    assign wrap     = wrap_q;
    assign done     = done_q;
    assign ctrl_dbg = ctrl_q;

endmodule

// File: tb/tb_seq_step_ctrl.sv
// Directed bench for seq_step_ctrl: full default run, infinite loop with stop,
// pause/single-step, last_step=0, ignored starts, and asynchronous reset.
module tb_seq_step_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       step = 1'b0;
    logic [8:0] last_step = '0;
    logic [7:0] loop_count = '0;
    logic [8:0] state;
    logic       busy, adv, wrap, done;
    logic [1:0] ctrl_dbg;

    int checks = 0;
    int failures = 0;
    int adv_cnt;

    seq_step_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .step(step), .last_step(last_step), .loop_count(loop_count),
        .state(state), .busy(busy), .adv(adv), .wrap(wrap), .done(done),
        .ctrl_dbg(ctrl_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // state, busy, adv, wrap, done in one call
    task automatic chk_all(input string tag, input int s, input bit b, input bit a,
                           input bit w, input bit d);
        chk({tag, ".state"}, 32'(state), 32'(s));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".adv"},   32'(adv),   32'(a));
        chk({tag, ".wrap"},  32'(wrap),  32'(w));
        chk({tag, ".done"},  32'(done),  32'(d));
    endtask

    initial begin
        // Reset
        #2;
        chk_all("reset", 0, 0, 0, 0, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk_all("post_reset", 0, 0, 0, 0, 0);

        // 1: full default run, last_step=259, one pass
        last_step = 9'd259; loop_count = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("t1_accept", 0, 1, 0, 0, 0);
        adv_cnt = 0;
        for (int i = 1; i <= 259; i++) begin
            tick();
            if (adv) adv_cnt++;
            chk("t1_state", 32'(state), 32'(i));
            chk("t1_wrap", 32'(wrap), 32'd0);
        end
        tick();
        if (adv) adv_cnt++;
        chk_all("t1_end", 0, 0, 1, 1, 1);
        chk("t1_adv_count", 32'(adv_cnt), 32'd260);
        tick();
        chk_all("t1_idle", 0, 0, 0, 0, 0);
        chk("t1_ctrl_idle", 32'(ctrl_dbg), 32'd0);

        // 2: infinite loop over 0..3, stop at state 2
        last_step = 9'd3; loop_count = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("t2_accept", 0, 1, 0, 0, 0);
        tick(); chk_all("t2_s1", 1, 1, 1, 0, 0);
        tick(); chk_all("t2_s2", 2, 1, 1, 0, 0);
        tick(); chk_all("t2_s3", 3, 1, 1, 0, 0);
        tick(); chk_all("t2_wrap", 0, 1, 1, 1, 0);
        tick(); chk_all("t2_s1b", 1, 1, 1, 0, 0);
        tick(); chk_all("t2_s2b", 2, 1, 1, 0, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_all("t2_stop", 0, 0, 0, 0, 0);

        // 3: pause and single-step
        last_step = 9'd5; loop_count = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("t3_accept", 0, 1, 0, 0, 0);
        tick(); chk_all("t3_s1", 1, 1, 1, 0, 0);
        tick(); chk_all("t3_s2", 2, 1, 1, 0, 0);
        pause = 1'b1;
        tick(); chk_all("t3_hold_enter", 2, 1, 0, 0, 0);
        chk("t3_ctrl_hold", 32'(ctrl_dbg), 32'd2);
        tick(); chk_all("t3_hold_stay", 2, 1, 0, 0, 0);
        step = 1'b1;
        tick(); chk_all("t3_step1", 3, 1, 1, 0, 0);
        step = 1'b0;
        tick(); chk_all("t3_hold_3", 3, 1, 0, 0, 0);
        step = 1'b1;
        tick(); chk_all("t3_step2", 4, 1, 1, 0, 0);
        step = 1'b0; pause = 1'b0;
        tick(); chk_all("t3_resume", 4, 1, 0, 0, 0);
        tick(); chk_all("t3_s5", 5, 1, 1, 0, 0);
        tick(); chk_all("t3_done", 0, 0, 1, 1, 1);

        // 4: last_step=0, three passes, restart in DONE cycle
        last_step = 9'd0; loop_count = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("t4_accept", 0, 1, 0, 0, 0);
        tick(); chk_all("t4_pass1", 0, 1, 1, 1, 0);
        tick(); chk_all("t4_pass2", 0, 1, 1, 1, 0);
        tick(); chk_all("t4_pass3", 0, 0, 1, 1, 1);
        chk("t4_ctrl_done", 32'(ctrl_dbg), 32'd3);
        loop_count = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("t4_restart", 0, 1, 0, 0, 0);
        tick(); chk_all("t4_re_done", 0, 0, 1, 1, 1);
        tick(); chk_all("t4_idle", 0, 0, 0, 0, 0);

        // 5: start+stop together from IDLE; start while RUN ignored
        last_step = 9'd4; loop_count = 8'd1; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk_all("t5_start_stop", 0, 0, 0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("t5_accept", 0, 1, 0, 0, 0);
        tick(); chk_all("t5_s1", 1, 1, 1, 0, 0);
        last_step = 9'd2; loop_count = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("t5_ignored", 2, 1, 1, 0, 0);
        tick(); chk_all("t5_s3", 3, 1, 1, 0, 0);
        tick(); chk_all("t5_s4", 4, 1, 1, 0, 0);
        tick(); chk_all("t5_done", 0, 0, 1, 1, 1);

        // 6: async reset mid-run at state 100
        last_step = 9'd259; loop_count = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        chk_all("t6_s100", 100, 1, 1, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk_all("t6_reset", 0, 0, 0, 0, 0);
        tick();
        #1 rst_n = 1'b1;
        last_step = 9'd2; loop_count = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("t6_accept", 0, 1, 0, 0, 0);
        tick(); chk_all("t6_s1", 1, 1, 1, 0, 0);
        tick(); chk_all("t6_s2", 2, 1, 1, 0, 0);
        tick(); chk_all("t6_done", 0, 0, 1, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_step_ctrl.md
Name: seq_step_ctrl

Overview:
Run controller for the design's 9-bit step sequencer. It replaces a free-running 260-step wrap counter with a controlled sequence: start/stop, pause, single-step, programmable last step and loop count. It emits `wrap` and `done` strobes for downstream datapath blocks. It owns the step register; consumers read `state`.

Parameters:
STATE_W, 9, width of step index `state` and `last_step`
LOOP_W, 8, width of `loop_count` and the internal loop counter
DEF_LAST, 259, documentation default for `last_step` (full 260-step sequence); not used in logic

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  pulse; begin a sequence (accepted only in IDLE or DONE)
stop  in  1  level/pulse; abort to IDLE, highest priority
pause  in  1  level; hold the step while high (RUN <-> HOLD)
step  in  1  pulse; advance exactly one step while in HOLD
last_step  in  STATE_W  final step index; sampled on accepted start
loop_count  in  LOOP_W  number of passes; 0 = infinite; sampled on accepted start
state  out  STATE_W  current step index, registered
busy  out  1  high in RUN or HOLD
adv  out  1  one-cycle strobe: `state` changed on the previous edge due to an advance
wrap  out  1  one-cycle strobe: previous advance went from last_q to 0
done  out  1  one-cycle strobe: final pass completed

Behaviour:
- Reset (async, rst_n=0):
  - ctrl=IDLE, state=0, last_q=0, loops_left=0, inf_q=0.
  - busy=adv=wrap=done=0. All outputs registered.
- Controller states: IDLE, RUN, HOLD, DONE.
- Priority per edge: stop > start > pause > step.
- stop=1, any state:
  - ctrl<=IDLE, state<=0, adv/wrap/done<=0.
  - No done pulse.
- IDLE or DONE with start=1:
  - last_q<=last_step, loops_left<=loop_count, inf_q<=(loop_count==0), state<=0.
  - ctrl<=HOLD if pause=1, else RUN.
  - No advance on the accept edge.
- start in RUN/HOLD: ignored. Latched values are unchanged.
- Advance operation, applied in RUN with pause=0, or in HOLD on a step pulse:
  - If state != last_q: state<=state+1, adv<=1.
  - If state == last_q (or state > last_q, defensive): state<=0, adv<=1, wrap<=1.
    - If inf_q=0 and loops_left==1: ctrl<=DONE, done<=1, loops_left<=0.
    - Else if inf_q=0: loops_left<=loops_left-1.
- RUN: pause=1 -> ctrl<=HOLD with no advance that edge; otherwise advance every cycle.
- HOLD: pause=0 -> ctrl<=RUN with no advance that edge. The step pulse is honoured only while pause=1.
- DONE: lasts one cycle, busy=0, state=0. Next edge goes to IDLE unless start or stop applies.
- Latency:
  - start accepted at edge t gives state=0, busy=1 after t.
  - state=1 after t+1 in RUN.
  - A pass of last_q+1 steps takes last_q+1 advancing edges.
- last_step=0: state stays 0, and wrap=adv=1 on every advancing cycle.
- Full default run (last_step=259, loop_count=1): state steps 0..259, then 0, with wrap=done=1 in the same cycle.
- Step arithmetic is unsigned STATE_W. Wrap is by compare only; the counter never overflows past last_q.
- rst_n asserted mid-operation: immediate return to reset values. Any in-flight strobe is cleared.

Test Plan:
1. Reset, then start with last_step=259, loop_count=1, pause=0 -> state 0,1,...,259 on consecutive cycles. Next cycle state=0 with wrap=1, done=1, busy=0. Exactly 260 adv strobes.
2. start with last_step=3, loop_count=0 -> state 0,1,2,3,0,... with wrap every 4th advance and done never high. stop at state=2 -> next cycle state=0, busy=0, done=0.
3. last_step=5, loop_count=1; raise pause at state=2 -> state held at 2 and busy=1. Two step pulses give 3 then 4. Drop pause -> one hold edge, then 5, then 0 with done=1.
4. last_step=0, loop_count=3 -> wrap=1 for 3 consecutive cycles, done=1 on the third, then IDLE. A new start in the DONE cycle is accepted.
5. start and stop in the same cycle from IDLE -> stays IDLE, busy=0. start while RUN with a different last_step -> ignored; the original wrap point is preserved.
6. Drive rst_n low while RUN at state=100 -> state=0 and all strobes 0 immediately. Release, then start -> normal sequence from 0.
